// File: rtl/uart_rx_ctrl_if.sv
// Receive-side bus for uart_rx_ctrl: character strobe from the receiver
// datapath and the software read port of the receive FIFO.
interface uart_rx_ctrl_if #(
    parameter int unsigned RxFifoDepth = 8
);
    localparam int unsigned DepthW = $clog2(RxFifoDepth) + 1;

    logic              rx_valid_i;
    logic [7:0]        rx_data_i;
    logic              frame_err_i;
    logic              parity_err_i;
    logic              rd_req_i;
    logic [7:0]        rd_data_o;
    logic [DepthW-1:0] fifo_depth_o;

    modport master (
        output rx_valid_i, rx_data_i, frame_err_i, parity_err_i, rd_req_i,
        input  rd_data_o, fifo_depth_o
    );

    modport slave (
        input  rx_valid_i, rx_data_i, frame_err_i, parity_err_i, rd_req_i,
        output rd_data_o, fifo_depth_o
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: enable/break FSM, receive FIFO with watermark and
// overflow events, error event pulses. Optional idle timeout is built only
// when the macro UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
    parameter int unsigned RxFifoDepth = 8
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic                             rx_en_i,
    output logic                             rx_enable_o,
    uart_rx_ctrl_if.slave                    rx_bus,
    input  logic                             tick_baud_i,
    input  logic                             fifo_clr_i,
    input  logic [$clog2(RxFifoDepth):0]     wm_level_i,
    input  logic [15:0]                      timeout_val_i,
    output logic                             intr_watermark_o,
    output logic                             intr_overflow_o,
    output logic                             intr_frame_err_o,
    output logic                             intr_parity_err_o,
    output logic                             intr_break_o,
    output logic                             intr_timeout_o
);
    localparam int unsigned AW     = $clog2(RxFifoDepth);
    localparam int unsigned DepthW = AW + 1;
    localparam logic [DepthW-1:0] FullLvl = DepthW'(RxFifoDepth);

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        ACTIVE   = 2'd1,
        BREAK    = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              accept;
    logic              brk_evt, fe_evt, pe_evt;

    logic [7:0]        mem [RxFifoDepth];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [DepthW-1:0] depth_q, depth_d;
    logic              empty, full, push, pop, ovf_evt, wm_evt;

    // Registered copy of the software enable for the receiver datapath
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rx_enable_o <= 1'b0;
        else         rx_enable_o <= rx_en_i;
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= DISABLED;
        else         state_q <= state_d;
    end

    // Next state and character classification
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        brk_evt = 1'b0;
        fe_evt  = 1'b0;
        pe_evt  = 1'b0;
        case (state_q)
            DISABLED: begin
                if (rx_en_i) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (rx_bus.rx_valid_i) begin
                    if (rx_bus.frame_err_i && (rx_bus.rx_data_i == 8'h00)) begin
                        brk_evt = 1'b1;
                        state_d = BREAK;
                    end else begin
                        accept = 1'b1;
                        fe_evt = rx_bus.frame_err_i;
                        pe_evt = rx_bus.parity_err_i;
                    end
                end
            end
            BREAK: begin
                // Any framing-error character stays inside the break; the
                // first clean-framed one ends it and is handled normally.
                if (rx_bus.rx_valid_i && !rx_bus.frame_err_i) begin
                    accept  = 1'b1;
                    pe_evt  = rx_bus.parity_err_i;
                    state_d = ACTIVE;
                end
            end
            default: state_d = DISABLED;
        endcase
        if (!rx_en_i) state_d = DISABLED;
    end

    // FIFO push/pop arbitration, occupancy and event detection
    always_comb begin
        empty   = (depth_q == '0);
        full    = (depth_q == FullLvl);
        pop     = rx_bus.rd_req_i && !empty && !fifo_clr_i;
        push    = accept && (!full || pop) && !fifo_clr_i;
        ovf_evt = accept && full && !pop && !fifo_clr_i;
        depth_d = depth_q;
        if (fifo_clr_i)         depth_d = '0;
        else if (push && !pop)  depth_d = depth_q + DepthW'(1);
        else if (pop && !push)  depth_d = depth_q - DepthW'(1);
        wm_evt  = (wm_level_i != '0) && (depth_q < wm_level_i) &&
                  (depth_d >= wm_level_i);
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            depth_q  <= '0;
        end else begin
            depth_q <= depth_d;
            if (fifo_clr_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    // FIFO storage; contents are only visible through the non-empty head
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= rx_bus.rx_data_i;
    end

    assign rx_bus.rd_data_o    = empty ? 8'h00 : mem[rd_ptr_q];
    assign rx_bus.fifo_depth_o = depth_q;

    // One-cycle event pulses, registered one cycle after their cause
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            intr_watermark_o  <= 1'b0;
            intr_overflow_o   <= 1'b0;
            intr_frame_err_o  <= 1'b0;
            intr_parity_err_o <= 1'b0;
            intr_break_o      <= 1'b0;
        end else begin
            intr_watermark_o  <= wm_evt;
            intr_overflow_o   <= ovf_evt;
            intr_frame_err_o  <= fe_evt;
            intr_parity_err_o <= pe_evt;
            intr_break_o      <= brk_evt;
        end
    end

`ifdef UART_RX_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        to_evt;

    // Idle timeout counter: counts baud ticks while data waits unread
    always_comb begin
        to_cnt_d = to_cnt_q;
        to_evt   = 1'b0;
        if (fifo_clr_i || push || pop || empty) begin
            to_cnt_d = '0;
        end else if (tick_baud_i && (state_q == ACTIVE) &&
                     (to_cnt_q != timeout_val_i)) begin
            // Stops at the threshold so the event fires only once.
            to_cnt_d = to_cnt_q + 16'd1;
            to_evt   = (to_cnt_d == timeout_val_i) && (timeout_val_i != '0);
        end
    end

    // Timeout counter and event register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            to_cnt_q       <= '0;
            intr_timeout_o <= 1'b0;
        end else begin
            to_cnt_q       <= to_cnt_d;
            intr_timeout_o <= to_evt;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^{timeout_val_i, tick_baud_i};
    assign intr_timeout_o     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed, table-driven bench for uart_rx_ctrl (RxFifoDepth = 8).
module tb_uart_rx_ctrl;
    localparam logic [5:0] WM  = 6'b100000;
    localparam logic [5:0] OVF = 6'b010000;
    localparam logic [5:0] FE  = 6'b001000;
    localparam logic [5:0] PE  = 6'b000100;
    localparam logic [5:0] BRK = 6'b000010;
`ifdef UART_RX_TIMEOUT_EN
    localparam logic [5:0] TOX = 6'b000001;
`else
    localparam logic [5:0] TOX = 6'b000000;
`endif

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        rx_en_i = 1'b0;
    logic        rx_enable_o;
    logic        tick_baud_i = 1'b0;
    logic        fifo_clr_i = 1'b0;
    logic [3:0]  wm_level_i = '0;
    logic [15:0] timeout_val_i = 16'd4;
    logic        intr_watermark_o, intr_overflow_o, intr_frame_err_o;
    logic        intr_parity_err_o, intr_break_o, intr_timeout_o;
    logic [5:0]  irq;

    uart_rx_ctrl_if #(.RxFifoDepth(8)) bus ();

    uart_rx_ctrl #(.RxFifoDepth(8)) dut (
        .clk_i             (clk_i),
        .rst_ni            (rst_ni),
        .rx_en_i           (rx_en_i),
        .rx_enable_o       (rx_enable_o),
        .rx_bus            (bus),
        .tick_baud_i       (tick_baud_i),
        .fifo_clr_i        (fifo_clr_i),
        .wm_level_i        (wm_level_i),
        .timeout_val_i     (timeout_val_i),
        .intr_watermark_o  (intr_watermark_o),
        .intr_overflow_o   (intr_overflow_o),
        .intr_frame_err_o  (intr_frame_err_o),
        .intr_parity_err_o (intr_parity_err_o),
        .intr_break_o      (intr_break_o),
        .intr_timeout_o    (intr_timeout_o)
    );

    always #5 clk_i = ~clk_i;

    assign irq = {intr_watermark_o, intr_overflow_o, intr_frame_err_o,
                  intr_parity_err_o, intr_break_o, intr_timeout_o};

    typedef struct {
        logic       en, vld;
        logic [7:0] d;
        logic       fe, pe, rd, clr, tick;
        logic [3:0] wm;
        logic [3:0] dep;
        logic [7:0] rdd;
        logic [5:0] irq;
    } vec_t;

    vec_t       vq[$];
    logic [3:0] cur_wm = '0;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got 0x%0h expected 0x%0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic en, vld, input logic [7:0] d, input logic fe, pe, rd, clr, tick,
                       input logic [3:0] dep, input logic [7:0] rdd, input logic [5:0] ir);
        vec_t v;
        v.en = en; v.vld = vld; v.d = d; v.fe = fe; v.pe = pe; v.rd = rd; v.clr = clr;
        v.tick = tick; v.wm = cur_wm; v.dep = dep; v.rdd = rdd; v.irq = ir;
        vq.push_back(v);
    endtask

    task automatic drive(input logic en, vld, input logic [7:0] d, input logic fe, pe, rd, clr, tick);
        rx_en_i = en; bus.rx_valid_i = vld; bus.rx_data_i = d; bus.frame_err_i = fe;
        bus.parity_err_i = pe; bus.rd_req_i = rd; fifo_clr_i = clr; tick_baud_i = tick;
    endtask

    task automatic chk_all_zero(input string name, input int idx);
        chk({name, "_depth"}, idx, 32'(bus.fifo_depth_o), 32'd0);
        chk({name, "_rdata"}, idx, 32'(bus.rd_data_o), 32'd0);
        chk({name, "_intr"}, idx, 32'(irq), 32'd0);
        chk({name, "_rxen"}, idx, 32'(rx_enable_o), 32'd0);
    endtask

    initial begin
        drive(0, 0, 8'h00, 0, 0, 0, 0, 0);
        // Vector table: expected values describe outputs after the edge that samples the row.
        add(0, 1, 8'h99, 0, 0, 0, 0, 0, 4'd0, 8'h00, 6'd0);
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0, 8'h00, 6'd0);
        add(1, 1, 8'h41, 0, 0, 0, 0, 0, 4'd1, 8'h41, 6'd0);
        add(1, 1, 8'h42, 0, 0, 0, 0, 0, 4'd2, 8'h41, 6'd0);
        add(1, 1, 8'h43, 0, 0, 0, 0, 0, 4'd3, 8'h41, 6'd0);
        add(1, 0, 8'h00, 0, 0, 1, 0, 0, 4'd2, 8'h42, 6'd0);
        add(1, 0, 8'h00, 0, 0, 1, 0, 0, 4'd1, 8'h43, 6'd0);
        add(1, 0, 8'h00, 0, 0, 1, 0, 0, 4'd0, 8'h00, 6'd0);
        add(1, 0, 8'h00, 0, 0, 1, 0, 0, 4'd0, 8'h00, 6'd0);
        add(1, 1, 8'h10, 1, 0, 0, 0, 0, 4'd1, 8'h10, FE);
        add(1, 1, 8'h20, 0, 1, 0, 0, 0, 4'd2, 8'h10, PE);
        add(1, 0, 8'h00, 0, 0, 1, 0, 0, 4'd1, 8'h20, 6'd0);
        add(1, 0, 8'h00, 0, 0, 1, 0, 0, 4'd0, 8'h00, 6'd0);
        add(1, 1, 8'h00, 1, 0, 0, 0, 0, 4'd0, 8'h00, BRK);
        add(1, 1, 8'h00, 1, 0, 0, 0, 0, 4'd0, 8'h00, 6'd0);
        add(1, 1, 8'h55, 0, 0, 0, 0, 0, 4'd1, 8'h55, 6'd0);
        add(1, 0, 8'h00, 0, 0, 1, 0, 0, 4'd0, 8'h00, 6'd0);
        add(1, 1, 8'h00, 1, 0, 0, 0, 0, 4'd0, 8'h00, BRK);
        add(1, 1, 8'h77, 0, 1, 0, 0, 0, 4'd1, 8'h77, PE);
        add(1, 0, 8'h00, 0, 0, 1, 0, 0, 4'd0, 8'h00, 6'd0);
        for (int i = 1; i <= 8; i++)
            add(1, 1, 8'(i), 0, 0, 0, 0, 0, 4'(i), 8'h01, 6'd0);
        add(1, 1, 8'h09, 0, 0, 0, 0, 0, 4'd8, 8'h01, OVF);
        add(1, 1, 8'h09, 0, 0, 1, 0, 0, 4'd8, 8'h02, 6'd0);
        for (int k = 0; k < 8; k++)
            add(1, 0, 8'h00, 0, 0, 1, 0, 0, 4'(7 - k), (k < 7) ? 8'(3 + k) : 8'h00, 6'd0);
        cur_wm = 4'd4;
        for (int i = 0; i < 4; i++)
            add(1, 1, 8'(8'hA0 + i), 0, 0, 0, 0, 0, 4'(i + 1), 8'hA0, (i == 3) ? WM : 6'd0);
        add(1, 0, 8'h00, 0, 0, 1, 0, 0, 4'd3, 8'hA1, 6'd0);
        add(1, 1, 8'hA4, 0, 0, 0, 0, 0, 4'd4, 8'hA1, WM);
        add(1, 1, 8'hA5, 0, 0, 0, 0, 0, 4'd5, 8'hA1, 6'd0);
        add(1, 0, 8'h00, 0, 0, 0, 1, 0, 4'd0, 8'h00, 6'd0);
        cur_wm = 4'd0;
        add(1, 1, 8'hB0, 0, 0, 0, 0, 0, 4'd1, 8'hB0, 6'd0);
        add(1, 1, 8'hB1, 0, 0, 0, 0, 0, 4'd2, 8'hB0, 6'd0);
        add(1, 1, 8'hC0, 0, 0, 1, 1, 0, 4'd0, 8'h00, 6'd0);
        add(1, 1, 8'hC1, 0, 0, 0, 0, 0, 4'd1, 8'hC1, 6'd0);
        add(0, 0, 8'h00, 0, 0, 0, 0, 0, 4'd1, 8'hC1, 6'd0);
        add(0, 1, 8'hD0, 0, 0, 0, 0, 0, 4'd1, 8'hC1, 6'd0);
        add(0, 0, 8'h00, 0, 0, 1, 0, 0, 4'd0, 8'h00, 6'd0);
        add(1, 0, 8'h00, 0, 0, 0, 0, 0, 4'd0, 8'h00, 6'd0);
        add(1, 1, 8'hE0, 0, 0, 0, 0, 0, 4'd1, 8'hE0, 6'd0);
        for (int t = 1; t <= 6; t++)
            add(1, 0, 8'h00, 0, 0, 0, 0, 1, 4'd1, 8'hE0, (t == 4) ? TOX : 6'd0);
        add(1, 0, 8'h00, 0, 0, 1, 0, 0, 4'd0, 8'h00, 6'd0);

        // Reset state
        repeat (2) @(posedge clk_i);
        #1 chk_all_zero("reset", 0);
        @(negedge clk_i) rst_ni = 1'b1;

        foreach (vq[i]) begin
            drive(vq[i].en, vq[i].vld, vq[i].d, vq[i].fe, vq[i].pe, vq[i].rd, vq[i].clr, vq[i].tick);
            wm_level_i = vq[i].wm;
            @(posedge clk_i);
            #1;
            chk("depth", i, 32'(bus.fifo_depth_o), 32'(vq[i].dep));
            chk("rdata", i, 32'(bus.rd_data_o), 32'(vq[i].rdd));
            chk("intr", i, 32'(irq), 32'(vq[i].irq));
            chk("rx_enable", i, 32'(rx_enable_o), 32'(vq[i].en));
        end

        // Reset asserted in the middle of a character with data buffered
        drive(1, 1, 8'hF1, 0, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        drive(1, 1, 8'hF2, 0, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        chk("pre_rst_depth", 0, 32'(bus.fifo_depth_o), 32'd2);
        drive(1, 1, 8'h00, 1, 1, 1, 0, 1);
        #2 rst_ni = 1'b0;
        #1 chk_all_zero("mid_rst", 0);
        @(posedge clk_i); #1 chk_all_zero("mid_rst", 1);
        drive(1, 0, 8'h00, 0, 0, 0, 0, 0);
        @(negedge clk_i) rst_ni = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk_i); #1;
            chk("post_rst_intr", c, 32'(irq), 32'd0);
            chk("post_rst_depth", c, 32'(bus.fifo_depth_o), 32'd0);
        end
        drive(1, 1, 8'h5A, 0, 0, 0, 0, 0);
        @(posedge clk_i); #1;
        drive(1, 0, 8'h00, 0, 0, 0, 0, 0);
        chk("post_rst_wr_depth", 0, 32'(bus.fifo_depth_o), 32'd1);
        chk("post_rst_wr_data", 0, 32'(bus.rd_data_o), 32'h5A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
